serial_add_driver: RTL and testbench
====================================

Name: serial_add_driver

Overview:
- Host-side companion to the team's bit-serial adder FSM: the other end of its A/B/S serial interface.
- Accepts two parallel WIDTH-bit operands on a start strobe.
- Clears the adder, then streams operand bits LSB-first into the adder's A/B inputs while gating its enable.
- Collects the returned serial sum bits and presents a parallel WIDTH+1-bit result, including carry-out, with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; latched on accepted start.
- b_in  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high in CLEAR/PRIME/SHIFT/DRAIN.
- done  output  1  high for exactly one cycle (DONE state).
- sum_out  output  WIDTH+1  result, LSB = bit 0; held until the next accepted start completes.
- ser_a  output  1  serial A bit to adder.
- ser_b  output  1  serial B bit to adder.
- ser_en  output  1  adder enable; high only in SHIFT/PRIME.
- ser_rst  output  1  adder reset = rst OR (state==CLEAR); combinational.
- ser_s  input  1  adder's Moore sum output.

Behaviour:
- Reset (rst=1 at posedge), from any state including mid-SHIFT: state=IDLE; busy=0, done=0, sum_out=0; shift registers and bit counter cleared; ser_a=ser_b=ser_en=0. ser_rst is high while rst is high.
- States: IDLE, CLEAR, PRIME (feature only), SHIFT, DRAIN, DONE. Outputs are Moore (decoded from state and registers).
- IDLE: start=1 → latch opA={1'b0,a_in} and opB={1'b0,b_in} (WIDTH+1 bits, zero-extended); bit counter=0; go to CLEAR. start=0 → stay.
- CLEAR: one cycle, ser_rst=1, ser_en=0; go to SHIFT.
- SHIFT: WIDTH+1 cycles with ser_en=1, ser_a=opA[0], ser_b=opB[0].
  - Each posedge: opA/opB shift right by 1 (zero fill); counter increments.
  - In SHIFT cycle k≥1, ser_s holds sum bit k-1 (the adder updates state on the edge that consumes a bit, so S lags one cycle). Capture it into result shift register bit position k-1 (shift-in at MSB, shift right).
  - After cycle k=WIDTH, go to DRAIN.
- DRAIN: ser_en=0; capture ser_s as bit WIDTH (the carry, produced by the 0+0 extension bit); go to DONE.
- DONE: one cycle; done=1, busy=0; sum_out updated from the result register on entry to DONE; start ignored; go to IDLE.
- Latency: start sampled at edge t → done high in cycle t+WIDTH+4 (t+12 for WIDTH=8).
- start while busy or in DONE: ignored, no effect on operands or result.
- Arithmetic: sum_out = a_in + b_in, unsigned, WIDTH+1 bits; never truncated.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled with start.
  - If sub=1: latch opB={1'b0,~b_in}; insert PRIME between CLEAR and SHIFT. PRIME is one cycle with ser_en=1 and ser_a=ser_b=1, driving the adder from carry-0 to carry-1 with S=0; no capture in PRIME.
  - Result: sum_out[WIDTH-1:0] = a_in - b_in mod 2^WIDTH; sum_out[WIDTH] = 1 when a_in ≥ b_in (no borrow).
  - Latency with sub=1 is WIDTH+5.
  - If sub=0: identical to the base block.
- Undefined: no sub port, no PRIME state; addition only.

Test Plan (WIDTH=8):
- rst=1 for 2 cycles → busy=0, done=0, sum_out=0x000, ser_en=0, ser_rst=1; after release ser_rst=0.
- start with a_in=0x3C, b_in=0x05 → ser_rst high 1 cycle; ser_en high 9 cycles; done pulses exactly at start-edge+12; sum_out=0x041.
- a_in=0xFF, b_in=0x01 → sum_out=0x100. Then a_in=0xFF, b_in=0xFF → sum_out=0x1FE (carry retained in bit 8).
- start re-asserted with different operands during SHIFT and in DONE → ignored; first result unchanged, next start accepted only from IDLE.
- rst pulsed in 4th SHIFT cycle → next cycle IDLE, busy=0, sum_out=0x000, no done; a following 0x10+0x20 run yields 0x030.
- SERIAL_ADD_SUB_EN, sub=1: a_in=0x05, b_in=0x07 → done at +13, sum_out=0x0FE; a_in=0x07, b_in=0x05 → sum_out=0x102.

Source files
------------

// File: rtl/serial_add_driver_if.sv
// Serial A/B/S bus between the host-side driver and the bit-serial adder.
// master: driver (ser_a/ser_b/ser_en/ser_rst out, ser_s in); slave: adder.
interface serial_add_driver_if;
    logic ser_a;
    logic ser_b;
    logic ser_en;
    logic ser_rst;
    logic ser_s;

    modport master (
        output ser_a, ser_b, ser_en, ser_rst,
        input  ser_s
    );

    modport slave (
        input  ser_a, ser_b, ser_en, ser_rst,
        output ser_s
    );
endinterface

// File: rtl/serial_add_driver.sv
// Parallel-to-serial driver for the bit-serial adder: latches two operands
// on start, clears the adder, streams bits LSB-first, collects the serial
// sum and presents it as a WIDTH+1 bit result with a one-cycle done pulse.
// Ports: clk, rst (sync, active high), start, a_in, b_in, busy, done,
// sum_out, bus (serial_add_driver_if.master: ser_a/b/en/rst out, ser_s in).
// Optional: SERIAL_ADD_SUB_EN adds input sub (a_in - b_in via ~b + 1).
module serial_add_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum_out,
    serial_add_driver_if.master bus
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
`ifdef SERIAL_ADD_SUB_EN
        PRIME = 3'd5,
`endif
        DONE  = 3'd4
    } state_t;

    state_t         state;
    state_t         nxt;
    logic [WIDTH:0] opa;
    logic [WIDTH:0] opb;
    logic [WIDTH:0] res;
    logic [CW-1:0]  cnt;
    logic           prime;
    logic [WIDTH:0] res_in;
    logic [WIDTH-1:0] b_sel;

    // New result bit enters at the MSB; after WIDTH+1 captures the
    // first captured bit has reached bit 0.
    assign res_in = {bus.ser_s, res[WIDTH:1]};

`ifdef SERIAL_ADD_SUB_EN
    logic sub_q;
    assign prime = (state == PRIME);
    assign b_sel = sub ? ~b_in : b_in;
`else
    assign prime = 1'b0;
    assign b_sel = b_in;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start) nxt = CLEAR;
`ifdef SERIAL_ADD_SUB_EN
            CLEAR: nxt = sub_q ? PRIME : SHIFT;
            PRIME: nxt = SHIFT;
`else
            CLEAR: nxt = SHIFT;
`endif
            SHIFT: if (cnt == LAST) nxt = DRAIN;
            DRAIN: nxt = DONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Moore outputs; PRIME feeds 1+1 to push the adder's carry to 1
    always_comb begin
        busy        = (state == CLEAR) || (state == SHIFT)
                   || (state == DRAIN) || prime;
        done        = (state == DONE);
        bus.ser_en  = (state == SHIFT) || prime;
        bus.ser_a   = ((state == SHIFT) && opa[0]) || prime;
        bus.ser_b   = ((state == SHIFT) && opb[0]) || prime;
        bus.ser_rst = rst || (state == CLEAR);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            opa     <= '0;
            opb     <= '0;
            res     <= '0;
            cnt     <= '0;
            sum_out <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    opa <= {1'b0, a_in};
                    opb <= {1'b0, b_sel};
                    res <= '0;
                    cnt <= '0;
`ifdef SERIAL_ADD_SUB_EN
                    sub_q <= sub;
`endif
                end
                SHIFT: begin
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    cnt <= cnt + 1'b1;
                    // ser_s lags the fed bit by one cycle
                    if (cnt != '0) res <= res_in;
                end
                DRAIN: begin
                    res     <= res_in;
                    sum_out <= res_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_driver.sv
// Randomised self-checking bench for serial_add_driver with a
// behavioural bit-serial adder attached to the serial bus.
module tb_serial_add_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W:0]   sum_out;

    int checks = 0;
    int errors = 0;

    serial_add_driver_if sif ();

    serial_add_driver #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .bus     (sif)
    );

    always #5 clk = ~clk;

    // Bit-serial adder: Moore sum, carry held between enabled edges
    logic carry = 1'b0;
    logic s_q   = 1'b0;
    always @(posedge clk) begin
        if (sif.ser_rst) begin
            carry <= 1'b0;
            s_q   <= 1'b0;
        end else if (sif.ser_en) begin
            s_q   <= sif.ser_a ^ sif.ser_b ^ carry;
            carry <= (sif.ser_a & sif.ser_b)
                   | (carry & (sif.ser_a ^ sif.ser_b));
        end
    end
    assign sif.ser_s = s_q;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic s);
        int unsigned ai = a;
        int unsigned bi = b;
        if (s) return {(ai >= bi), W'(ai - bi)};
        return (W+1)'(ai + bi);
    endfunction

    // junk: cycle (1 = first after accept) to pulse a rogue start;
    // 0 = none, -1 = during the DONE cycle
    task automatic run_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic s,
                          input int junk);
        logic [W:0] exp;
        int cyc;
        int en_n;
        int rs_n;
        exp = model(a, b, s);
        @(negedge clk);
        a_in = a; b_in = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom);
        cyc = 1; en_n = 0; rs_n = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (sif.ser_en) en_n++;
            if (sif.ser_rst) rs_n++;
            start = (cyc == junk);
            if (start) begin
                a_in = W'($urandom); b_in = W'($urandom);
                sub = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc, W + 4 + int'(s));
        chk("en_cycles", en_n, W + 1 + int'(s));
        chk("clr_cycles", rs_n, 1);
        chk("sum", sum_out, exp);
        chk("done_busy", busy, 0);
        if (junk == -1) begin
            start = 1'b1;
            a_in = W'($urandom); b_in = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("sum_hold", sum_out, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0;
        a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_en", sif.ser_en, 0);
        chk("rst_serrst", sif.ser_rst, 1);
        rst = 1'b0;
        #1;
        chk("rel_serrst", sif.ser_rst, 0);

        run_op(8'h3C, 8'h05, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b0, 0);
        run_op(8'h12, 8'h34, 1'b0, 5);
        run_op(8'h56, 8'h78, 1'b0, -1);

        // reset in the 4th SHIFT cycle (cycle 5 after accept)
        @(negedge clk);
        a_in = 8'hAA; b_in = 8'h55; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_sum", sum_out, 0);
        chk("mid_en", sif.ser_en, 0);
        begin
            int seen = 0;
            repeat (15) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("mid_nodone", seen, 0);
        end
        run_op(8'h10, 8'h20, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 0);
        run_op(8'h07, 8'h05, 1'b1, 0);
`endif

        for (int i = 0; i < 25; i++) begin
            logic s;
            int jk;
            s = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            s = 1'($urandom);
`endif
            jk = int'($urandom_range(0, W + 4)) - 1;
            run_op(W'($urandom), W'($urandom), s, jk);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
